// File: rtl/picosoc_gpio_if.sv
// PicoSoC iomem bus bundle used by the GPIO block.
// The master drives the request and the slave answers with a one-cycle ready and read data.
interface picosoc_gpio_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid,
        output iomem_wstrb,
        output iomem_addr,
        output iomem_wdata,
        input  iomem_ready,
        input  iomem_rdata
    );

    modport slave (
        input  iomem_valid,
        input  iomem_wstrb,
        input  iomem_addr,
        input  iomem_wdata,
        output iomem_ready,
        output iomem_rdata
    );
endinterface

// File: rtl/picosoc_gpio.sv
// Memory-mapped GPIO for PicoSoC: output/direction registers, synchronized pin inputs,
// and per-pin rise/fall edge interrupts with write-one-to-clear status.
module picosoc_gpio #(
    parameter int          WIDTH       = 32,
    parameter logic [7:0]  BASE_ADDR   = 8'h03,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    picosoc_gpio_if.slave        bus,
    input  logic [WIDTH-1:0]     gpio_in,
    output logic [WIDTH-1:0]     gpio_out,
    output logic [WIDTH-1:0]     gpio_oe,
    output logic                 irq
);

    typedef enum logic [2:0] {
        REG_DATA_OUT    = 3'd0,
        REG_DIR         = 3'd1,
        REG_DATA_IN     = 3'd2,
        REG_IRQ_RISE_EN = 3'd3,
        REG_IRQ_FALL_EN = 3'd4,
        REG_IRQ_STATUS  = 3'd5,
        REG_OUT_SET     = 3'd6,
        REG_OUT_CLR     = 3'd7
    } reg_idx_e;

    localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

    logic                               ready_q, ready_d;
    logic [31:0]                        rdata_q, rdata_d;
    logic [WIDTH-1:0]                   data_out_q, data_out_d;
    logic [WIDTH-1:0]                   dir_q, dir_d;
    logic [WIDTH-1:0]                   rise_en_q, rise_en_d;
    logic [WIDTH-1:0]                   fall_en_q, fall_en_d;
    logic [WIDTH-1:0]                   status_q, status_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]  sync_q, sync_d;
    logic [WIDTH-1:0]                   prev_q, prev_d;
    logic [2:0]                         arm_cnt_q, arm_cnt_d;

    logic                               sel;
    logic                               access;
    logic                               is_write;
    reg_idx_e                           reg_idx;
    logic [31:0]                        wmask32;
    logic [WIDTH-1:0]                   wmask;
    logic [WIDTH-1:0]                   wbits;
    logic [WIDTH-1:0]                   rd_val;
    logic [31:0]                        rd_val32;
    logic [WIDTH-1:0]                   sync_now;
    logic                               armed;
    logic [WIDTH-1:0]                   edge_set;
    logic [WIDTH-1:0]                   status_clr;
    logic                               unused_bits;

    // Address decode: only the top byte selects, the middle and low bits alias.
    always_comb begin
        sel      = bus.iomem_valid && (bus.iomem_addr[31:24] == BASE_ADDR);
        access   = sel && !ready_q;
        is_write = access && (bus.iomem_wstrb != 4'b0000);
        reg_idx  = reg_idx_e'(bus.iomem_addr[4:2]);
        wmask32  = {{8{bus.iomem_wstrb[3]}}, {8{bus.iomem_wstrb[2]}},
                    {8{bus.iomem_wstrb[1]}}, {8{bus.iomem_wstrb[0]}}};
        wmask    = wmask32[WIDTH-1:0];
        wbits    = bus.iomem_wdata[WIDTH-1:0] & wmask;
    end

    assign unused_bits = ^{bus.iomem_addr[23:5], bus.iomem_addr[1:0], bus.iomem_wdata, wmask32};

    always_comb begin
        rd_val = '0;
        case (reg_idx)
            REG_DATA_OUT:    rd_val = data_out_q;
            REG_DIR:         rd_val = dir_q;
            REG_DATA_IN:     rd_val = sync_now;
            REG_IRQ_RISE_EN: rd_val = rise_en_q;
            REG_IRQ_FALL_EN: rd_val = fall_en_q;
            REG_IRQ_STATUS:  rd_val = status_q;
            default:         rd_val = '0;
        endcase
        rd_val32              = '0;
        rd_val32[WIDTH-1:0]   = rd_val;
    end

    // Edge detection stays disarmed until the synchronizer has flushed its reset contents.
    always_comb begin
        sync_now  = sync_q[SYNC_STAGES-1];
        armed     = (arm_cnt_q == ARM_MAX);
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 3'd1;
        sync_d    = {sync_q[SYNC_STAGES-2:0], gpio_in};
        prev_d    = sync_now;
        edge_set  = armed ? ((sync_now & ~prev_q & rise_en_q) |
                             (~sync_now & prev_q & fall_en_q)) : '0;
    end

    always_comb begin
        ready_d    = access;
        rdata_d    = access ? rd_val32 : 32'h0;
        data_out_d = data_out_q;
        dir_d      = dir_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        status_clr = '0;
        if (is_write) begin
            case (reg_idx)
                REG_DATA_OUT:    data_out_d = (data_out_q & ~wmask) | wbits;
                REG_DIR:         dir_d      = (dir_q & ~wmask) | wbits;
                REG_IRQ_RISE_EN: rise_en_d  = (rise_en_q & ~wmask) | wbits;
                REG_IRQ_FALL_EN: fall_en_d  = (fall_en_q & ~wmask) | wbits;
                REG_IRQ_STATUS:  status_clr = wbits;
                REG_OUT_SET:     data_out_d = data_out_q | wbits;
                REG_OUT_CLR:     data_out_d = data_out_q & ~wbits;
                default:         data_out_d = data_out_q;
            endcase
        end
        // A new edge in the same cycle as a clear keeps the bit set.
        status_d = (status_q & ~status_clr) | edge_set;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q    <= 1'b0;
            rdata_q    <= 32'h0;
            data_out_q <= '0;
            dir_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            sync_q     <= '0;
            prev_q     <= '0;
            arm_cnt_q  <= 3'd0;
        end else begin
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            status_q   <= status_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            arm_cnt_q  <= arm_cnt_d;
        end
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign gpio_out        = data_out_q;
    assign gpio_oe         = dir_q;
    assign irq             = |status_q;

endmodule

// File: tb/tb_picosoc_gpio.sv
// Directed bench for picosoc_gpio: a register-access vector table followed by
// hand-written sequences for interrupt timing, clear/set collision, reset abort and arming.
module tb_picosoc_gpio;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        exp_ready;
        logic [31:0] exp_rdata;
        logic [31:0] exp_out;
        logic [31:0] exp_oe;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic        irq;
    logic [7:0]  gpio_in8;
    logic [7:0]  gpio_out8;
    logic [7:0]  gpio_oe8;
    logic        irq8;

    int vec_count  = 0;
    int miss_count = 0;

    picosoc_gpio_if bus32 ();
    picosoc_gpio_if bus8 ();

    always #5 clk = ~clk;

    picosoc_gpio #(.WIDTH(32), .BASE_ADDR(8'h03), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus32),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    picosoc_gpio #(.WIDTH(8), .BASE_ADDR(8'h03), .SYNC_STAGES(2)) dut8 (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus8),
        .gpio_in  (gpio_in8),
        .gpio_out (gpio_out8),
        .gpio_oe  (gpio_oe8),
        .irq      (irq8)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One bus transfer; waits a bounded number of edges for ready.
    task automatic busAccess(input bit narrow, input logic [31:0] addr, input logic [3:0] wstrb,
                             input logic [31:0] wdata, output logic [31:0] rdata, output logic got_ready);
        @(negedge clk);
        if (narrow) begin
            bus8.iomem_valid = 1'b1; bus8.iomem_addr = addr;
            bus8.iomem_wstrb = wstrb; bus8.iomem_wdata = wdata;
        end else begin
            bus32.iomem_valid = 1'b1; bus32.iomem_addr = addr;
            bus32.iomem_wstrb = wstrb; bus32.iomem_wdata = wdata;
        end
        got_ready = 1'b0;
        rdata     = 32'h0;
        for (int i = 0; i < 4 && !got_ready; i++) begin
            @(posedge clk);
            #1;
            if (narrow ? bus8.iomem_ready : bus32.iomem_ready) begin
                got_ready = 1'b1;
                rdata     = narrow ? bus8.iomem_rdata : bus32.iomem_rdata;
            end
        end
        @(negedge clk);
        bus8.iomem_valid  = 1'b0; bus8.iomem_wstrb  = 4'h0;
        bus32.iomem_valid = 1'b0; bus32.iomem_wstrb = 4'h0;
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [31:0] rd;
        logic        rdy;
        busAccess(1'b0, v.addr, v.wstrb, v.wdata, rd, rdy);
        checkOutput({v.name, " ready"}, {31'h0, rdy}, {31'h0, v.exp_ready});
        if (v.exp_ready)
            checkOutput({v.name, " rdata"}, rd, v.exp_rdata);
        checkOutput({v.name, " gpio_out"}, gpio_out, v.exp_out);
        checkOutput({v.name, " gpio_oe"}, gpio_oe, v.exp_oe);
    endtask

    task automatic readCheck(input string name, input bit narrow, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        rdy;
        busAccess(narrow, addr, 4'h0, 32'h0, rd, rdy);
        checkOutput({name, " ready"}, {31'h0, rdy}, 32'h1);
        checkOutput({name, " rdata"}, rd, exp);
    endtask

    task automatic writeReg(input bit narrow, input logic [31:0] addr, input logic [31:0] data, output logic [31:0] old);
        logic rdy;
        busAccess(narrow, addr, 4'hF, data, old, rdy);
        checkOutput("write ready", {31'h0, rdy}, 32'h1);
    endtask

    initial begin
        vec_t        vecs [14];
        logic [31:0] old;
        logic        rdy;

        vecs[0]  = '{"wr DATA_OUT A5",   32'h0300_0000, 4'b0001, 32'h0000_00A5, 1'b1, 32'h0,         32'h0000_00A5, 32'h0};
        vecs[1]  = '{"rd DATA_OUT",      32'h0300_0000, 4'b0000, 32'h0,         1'b1, 32'h0000_00A5, 32'h0000_00A5, 32'h0};
        vecs[2]  = '{"wr DIR",           32'h0300_0004, 4'b1111, 32'h0000_FFFF, 1'b1, 32'h0,         32'h0000_00A5, 32'h0000_FFFF};
        vecs[3]  = '{"alias lane2",      32'h03FF_FFE3, 4'b0100, 32'h1234_5678, 1'b1, 32'h0000_00A5, 32'h0034_00A5, 32'h0000_FFFF};
        vecs[4]  = '{"wr DATA_OUT F0",   32'h0300_0000, 4'b1111, 32'h0000_00F0, 1'b1, 32'h0034_00A5, 32'h0000_00F0, 32'h0000_FFFF};
        vecs[5]  = '{"OUT_SET 0F",       32'h0300_0018, 4'b1111, 32'h0000_000F, 1'b1, 32'h0,         32'h0000_00FF, 32'h0000_FFFF};
        vecs[6]  = '{"OUT_CLR 81",       32'h0300_001C, 4'b1111, 32'h0000_0081, 1'b1, 32'h0,         32'h0000_007E, 32'h0000_FFFF};
        vecs[7]  = '{"rd OUT_SET",       32'h0300_0018, 4'b0000, 32'h0,         1'b1, 32'h0,         32'h0000_007E, 32'h0000_FFFF};
        vecs[8]  = '{"rd OUT_CLR",       32'h0300_001C, 4'b0000, 32'h0,         1'b1, 32'h0,         32'h0000_007E, 32'h0000_FFFF};
        vecs[9]  = '{"unselected wr",    32'h0200_0000, 4'b1111, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'h0000_007E, 32'h0000_FFFF};
        vecs[10] = '{"rd DATA_OUT 7E",   32'h0300_0000, 4'b0000, 32'h0,         1'b1, 32'h0000_007E, 32'h0000_007E, 32'h0000_FFFF};
        vecs[11] = '{"wr DATA_IN",       32'h0300_0008, 4'b1111, 32'hDEAD_BEEF, 1'b1, 32'h0,         32'h0000_007E, 32'h0000_FFFF};
        vecs[12] = '{"OUT_SET lane1",    32'h0300_0018, 4'b0010, 32'hFFFF_FFFF, 1'b1, 32'h0,         32'h0000_FF7E, 32'h0000_FFFF};
        vecs[13] = '{"rd DIR",           32'h0300_0004, 4'b0000, 32'h0,         1'b1, 32'h0000_FFFF, 32'h0000_FF7E, 32'h0000_FFFF};

        resetn            = 1'b0;
        gpio_in           = 32'h0;
        gpio_in8          = 8'h0;
        bus32.iomem_valid = 1'b0; bus32.iomem_wstrb = 4'h0;
        bus32.iomem_addr  = 32'h0; bus32.iomem_wdata = 32'h0;
        bus8.iomem_valid  = 1'b0; bus8.iomem_wstrb  = 4'h0;
        bus8.iomem_addr   = 32'h0; bus8.iomem_wdata  = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ready", {31'h0, bus32.iomem_ready}, 32'h0);
        checkOutput("reset rdata", bus32.iomem_rdata, 32'h0);
        checkOutput("reset gpio_out", gpio_out, 32'h0);
        checkOutput("reset gpio_oe", gpio_oe, 32'h0);
        checkOutput("reset irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(posedge clk);

        for (int i = 0; i < 14; i++)
            applyStimulus(vecs[i]);

        // Ready lasts exactly one cycle even while valid stays high.
        @(negedge clk);
        bus32.iomem_valid = 1'b1; bus32.iomem_addr = 32'h0300_0000; bus32.iomem_wstrb = 4'h0;
        @(posedge clk); #1;
        checkOutput("ready pulse hi", {31'h0, bus32.iomem_ready}, 32'h1);
        @(posedge clk); #1;
        checkOutput("ready pulse lo", {31'h0, bus32.iomem_ready}, 32'h0);
        @(negedge clk);
        bus32.iomem_valid = 1'b0;

        // Rise interrupt latency with two synchronizer stages.
        writeReg(1'b0, 32'h0300_000C, 32'h1, old);
        @(negedge clk);
        gpio_in[0] = 1'b1;
        @(posedge clk); #1;
        checkOutput("irq after k", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        checkOutput("irq after k+1", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        checkOutput("irq after k+2", {31'h0, irq}, 32'h1);
        readCheck("rd STATUS rise", 1'b0, 32'h0300_0014, 32'h1);
        writeReg(1'b0, 32'h0300_0014, 32'h1, old);
        checkOutput("w1c old status", old, 32'h1);
        checkOutput("irq cleared", {31'h0, irq}, 32'h0);

        // Clear collides with a fresh rise on the same bit: the set wins.
        @(negedge clk);
        gpio_in[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        gpio_in[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        writeReg(1'b0, 32'h0300_0014, 32'h1, old);
        checkOutput("collide old status", old, 32'h0);
        checkOutput("collide irq", {31'h0, irq}, 32'h1);
        readCheck("collide status", 1'b0, 32'h0300_0014, 32'h1);
        writeReg(1'b0, 32'h0300_0014, 32'h1, old);
        checkOutput("irq after clear", {31'h0, irq}, 32'h0);

        // Fall edges, disabled rise on the same pin, and enable changes.
        writeReg(1'b0, 32'h0300_0010, 32'h2, old);
        @(negedge clk);
        gpio_in[1] = 1'b1;
        gpio_in[2] = 1'b1;
        repeat (5) @(posedge clk);
        readCheck("no status on bit1 rise", 1'b0, 32'h0300_0014, 32'h0);
        @(negedge clk);
        gpio_in[1] = 1'b0;
        repeat (5) @(posedge clk);
        readCheck("fall status", 1'b0, 32'h0300_0014, 32'h2);
        writeReg(1'b0, 32'h0300_0010, 32'h0, old);
        checkOutput("old FALL_EN", old, 32'h2);
        writeReg(1'b0, 32'h0300_000C, 32'h5, old);
        repeat (4) @(posedge clk);
        readCheck("status kept", 1'b0, 32'h0300_0014, 32'h2);
        readCheck("rd DATA_IN", 1'b0, 32'h0300_0008, 32'h5);

        // Reset in the middle of a transfer, pins high during reset.
        @(negedge clk);
        gpio_in           = 32'hFFFF_FFFF;
        bus32.iomem_valid = 1'b1; bus32.iomem_addr  = 32'h0300_0000;
        bus32.iomem_wstrb = 4'hF; bus32.iomem_wdata = 32'hFFFF_FFFF;
        #2 resetn = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort ready", {31'h0, bus32.iomem_ready}, 32'h0);
        checkOutput("abort rdata", bus32.iomem_rdata, 32'h0);
        checkOutput("abort gpio_out", gpio_out, 32'h0);
        checkOutput("abort gpio_oe", gpio_oe, 32'h0);
        checkOutput("abort irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        bus32.iomem_valid = 1'b0; bus32.iomem_wstrb = 4'h0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Rise enable written before arming completes must not latch the reset-time level.
        busAccess(1'b0, 32'h0300_000C, 4'hF, 32'hFFFF_FFFF, old, rdy);
        checkOutput("first after reset ready", {31'h0, rdy}, 32'h1);
        checkOutput("first after reset rdata", old, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("arming irq", {31'h0, irq}, 32'h0);
        readCheck("arming status", 1'b0, 32'h0300_0014, 32'h0);
        readCheck("DATA_IN ones", 1'b0, 32'h0300_0008, 32'hFFFF_FFFF);
        readCheck("DATA_OUT after abort", 1'b0, 32'h0300_0000, 32'h0);

        // Narrow build ignores bits above WIDTH.
        writeReg(1'b1, 32'h0300_0004, 32'hFFFF_FFFF, old);
        checkOutput("w8 gpio_oe", {24'h0, gpio_oe8}, 32'h0000_00FF);
        readCheck("w8 rd DIR", 1'b1, 32'h0300_0004, 32'h0000_00FF);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/picosoc_gpio.md
PICOSOC_GPIO -- requirements
Module: picosoc_gpio

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the number of GPIO pins (legal range 1..32).
REQ-002 Parameter BASE_ADDR [7:0], default 8'h03, SHALL be the value of iomem_addr[31:24] that selects the block.
REQ-003 Parameter SYNC_STAGES, default 2, SHALL be the input synchronizer depth (legal range 2..4).
REQ-004 Port clk, input, 1: the single clock; all flops SHALL be clocked on its rising edge.
REQ-005 Port resetn, input, 1: asynchronous active-low reset.
REQ-006 Port iomem_valid, input, 1: bus request.
REQ-007 Port iomem_ready, output, 1: one-cycle transfer acknowledge.
REQ-008 Port iomem_wstrb, input, 4: byte write strobes; 0 means read.
REQ-009 Port iomem_addr, input, 32: byte address.
REQ-010 Port iomem_wdata, input, 32: write data.
REQ-011 Port iomem_rdata, output, 32: read data, valid while iomem_ready=1.
REQ-012 Port gpio_in, input, WIDTH: asynchronous pin inputs.
REQ-013 Port gpio_out, output, WIDTH: output drive values (the DATA_OUT register).
REQ-014 Port gpio_oe, output, WIDTH: per-pin output enable (the DIR register, 1=drive).
REQ-015 Port irq, output, 1: level interrupt, equal to |IRQ_STATUS.

Function
REQ-016 Selection: sel = iomem_valid && iomem_addr[31:24]==BASE_ADDR; register index = iomem_addr[4:2]; addr[23:5] and addr[1:0] SHALL be ignored (aliasing).
REQ-017 Map: 0 DATA_OUT rw; 1 DIR rw; 2 DATA_IN ro; 3 IRQ_RISE_EN rw; 4 IRQ_FALL_EN rw; 5 IRQ_STATUS rw1c; 6 OUT_SET w1s (reads 0); 7 OUT_CLR w1c (reads 0).
REQ-018 Handshake: when sel && !iomem_ready at edge k, iomem_ready SHALL be 1 in the following cycle only, then 0; an unselected request SHALL never assert iomem_ready.
REQ-019 Writes and iomem_rdata SHALL be captured at the same edge that sets iomem_ready; iomem_rdata SHALL return the register value before that write.
REQ-020 Byte lane n SHALL be written only when iomem_wstrb[n]=1; bits at or above WIDTH SHALL be ignored on write and read as 0.
REQ-021 Writes to DATA_IN SHALL have no effect.
REQ-022 OUT_SET: DATA_OUT |= strobed wdata; OUT_CLR: DATA_OUT &= ~strobed wdata.
REQ-023 gpio_in SHALL pass through SYNC_STAGES flops; DATA_IN reads the synchronizer output; a prev register SHALL hold the previous synchronizer output.
REQ-024 rise = sync & ~prev & IRQ_RISE_EN; fall = ~sync & prev & IRQ_FALL_EN; IRQ_STATUS bit SHALL set on rise|fall at the next edge.
REQ-025 Latency: a stable pin change sampled at edge k SHALL set IRQ_STATUS (and irq) visible after edge k+SYNC_STAGES.
REQ-026 IRQ_STATUS write: strobed 1 bits clear; if set and clear coincide on a bit in the same cycle, set SHALL win.
REQ-027 Arming: a counter SHALL suppress edge detection until SYNC_STAGES+1 edges after reset release, so reset-time pin levels cause no status.
REQ-028 Edge-enable changes SHALL not retroactively set status; disabling an enable SHALL not clear existing status.

Reset
REQ-029 While resetn=0: iomem_ready=0, iomem_rdata=0, DATA_OUT=0, DIR=0, IRQ_*=0, synchronizers and prev=0, arming counter=0, irq=0, gpio_oe=0.
REQ-030 Reset asserted mid-transfer SHALL abort it with no register update; the first request after release SHALL complete normally.

Verification
REQ-031 Write 0x0000_00A5 to DATA_OUT, wstrb=4'b0001 -> iomem_ready one cycle later for one cycle; gpio_out=0xA5; readback 0x0000_00A5.
REQ-032 DATA_OUT=0xF0, write OUT_SET 0x0F then OUT_CLR 0x81 -> gpio_out 0xFF then 0x7E; reads of index 6/7 return 0.
REQ-033 IRQ_RISE_EN=0x1, gpio_in[0] 0->1 at edge k -> IRQ_STATUS=0x1, irq=1 after edge k+2 (SYNC_STAGES=2); write IRQ_STATUS 0x1 -> irq=0.
REQ-034 W1C of bit 0 in the same cycle a new enabled rise sets bit 0 -> bit stays 1, irq stays 1.
REQ-035 gpio_in=all ones with RISE_EN preset by post-reset write before arming completes -> no status set; WIDTH=8 build: write 0xFFFF_FFFF to DIR -> readback 0x0000_00FF.
REQ-036 Access with iomem_addr[31:24]=0x02 -> iomem_ready stays 0, no register changes.
